// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two sources (A = ALU, B = load) and the
// register-file write arbiter, including the write port and status outputs.
interface regfile_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic              b_ready;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic [7:0]        drop_cnt;

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      input  a_ready, b_ready, wr_en, wr_addr, wr_data, busy, drop_cnt
   );

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      output a_ready, b_ready, wr_en, wr_addr, wr_data, busy, drop_cnt
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between ALU (A) and load (B) writebacks.
// Macro REGWR_RR_EN: round-robin arbitration; undefined: A priority with B starvation escape.
module regfile_write_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input logic                    clk,
   input logic                    reset,
   regfile_write_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic              held_a_q, held_a_d;
   logic [ADDR_W-1:0] addr_a_q, addr_a_d;
   logic [DATA_W-1:0] data_a_q, data_a_d;
   logic              held_b_q, held_b_d;
   logic [ADDR_W-1:0] addr_b_q, addr_b_d;
   logic [DATA_W-1:0] data_b_q, data_b_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;
`ifdef REGWR_RR_EN
   logic              last_b_q, last_b_d;
`else
   logic [SW-1:0]     starve_q, starve_d;
`endif

   logic              grant_a_s, grant_b_s;
   logic              a_ready_s, b_ready_s;
   logic              acc_a_s, acc_b_s;
   logic              drop_a_s, drop_b_s;
   logic [8:0]        drop_sum_s;

   // Grant selection from registered state only, so ready never depends on valid.
   always_comb begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
      if (held_a_q && held_b_q) begin
`ifdef REGWR_RR_EN
         grant_b_s = !last_b_q;
`else
         grant_b_s = (starve_q >= SW'(STARVE_LIMIT));
`endif
         grant_a_s = !grant_b_s;
      end else begin
         grant_a_s = held_a_q;
         grant_b_s = held_b_q;
      end
   end

   assign a_ready_s = !held_a_q || grant_a_s;
   assign b_ready_s = !held_b_q || grant_b_s;
   assign acc_a_s   = bus.a_valid && a_ready_s;
   assign acc_b_s   = bus.b_valid && b_ready_s;
   assign drop_a_s  = acc_a_s && (bus.a_addr == ADDR_W'(0));
   assign drop_b_s  = acc_b_s && (bus.b_addr == ADDR_W'(0));
   assign drop_sum_s = {1'b0, drop_cnt_q} + 9'(drop_a_s) + 9'(drop_b_s);

   // Next-state for both holding slots; a same-cycle grant and accept refills without a bubble.
   always_comb begin
      held_a_d = held_a_q;
      addr_a_d = addr_a_q;
      data_a_d = data_a_q;
      held_b_d = held_b_q;
      addr_b_d = addr_b_q;
      data_b_d = data_b_q;
      if (acc_a_s && !drop_a_s) begin
         held_a_d = 1'b1;
         addr_a_d = bus.a_addr;
         data_a_d = bus.a_data;
      end else if (grant_a_s) begin
         held_a_d = 1'b0;
      end else begin
         held_a_d = held_a_q;
      end
      if (acc_b_s && !drop_b_s) begin
         held_b_d = 1'b1;
         addr_b_d = bus.b_addr;
         data_b_d = bus.b_data;
      end else if (grant_b_s) begin
         held_b_d = 1'b0;
      end else begin
         held_b_d = held_b_q;
      end
   end

   // Next-state for the write port, drop counter and arbitration history.
   always_comb begin
      wr_en_d   = grant_a_s || grant_b_s;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (grant_a_s) begin
         wr_addr_d = addr_a_q;
         wr_data_d = data_a_q;
      end else if (grant_b_s) begin
         wr_addr_d = addr_b_q;
         wr_data_d = data_b_q;
      end else begin
         wr_addr_d = wr_addr_q;
         wr_data_d = wr_data_q;
      end
      if (drop_sum_s > 9'd255) begin
         drop_cnt_d = 8'd255;
      end else begin
         drop_cnt_d = drop_sum_s[7:0];
      end
`ifdef REGWR_RR_EN
      if (grant_a_s || grant_b_s) begin
         last_b_d = grant_b_s;
      end else begin
         last_b_d = last_b_q;
      end
`else
      // Counter saturates at the limit; B then wins until granted.
      if (!held_b_q || grant_b_s) begin
         starve_d = '0;
      end else if (starve_q < SW'(STARVE_LIMIT)) begin
         starve_d = starve_q + SW'(1);
      end else begin
         starve_d = starve_q;
      end
`endif
   end

   // State registers with synchronous reset that discards any held entries.
   always_ff @(posedge clk) begin
      if (reset) begin
         held_a_q   <= 1'b0;
         addr_a_q   <= '0;
         data_a_q   <= '0;
         held_b_q   <= 1'b0;
         addr_b_q   <= '0;
         data_b_q   <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         drop_cnt_q <= 8'd0;
`ifdef REGWR_RR_EN
         last_b_q   <= 1'b0;
`else
         starve_q   <= '0;
`endif
      end else begin
         held_a_q   <= held_a_d;
         addr_a_q   <= addr_a_d;
         data_a_q   <= data_a_d;
         held_b_q   <= held_b_d;
         addr_b_q   <= addr_b_d;
         data_b_q   <= data_b_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         drop_cnt_q <= drop_cnt_d;
`ifdef REGWR_RR_EN
         last_b_q   <= last_b_d;
`else
         starve_q   <= starve_d;
`endif
      end
   end

   assign bus.a_ready  = a_ready_s;
   assign bus.b_ready  = b_ready_s;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.drop_cnt = drop_cnt_q;
   assign bus.busy     = held_a_q || held_b_q || wr_en_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued when
// stimulus is driven and popped whenever the DUT asserts wr_en.
module tb_regfile_write_arbiter;
   typedef logic [36:0] wr_t;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   wr_t  exp_q[$];

   regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every write the DUT issues must match the head of the queue.
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", bus.wr_addr, bus.wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if ({bus.wr_addr, bus.wr_data} !== e) begin
               miscompares++;
               $display("FAIL scoreboard: got addr=%0d data=%h, expected addr=%0d data=%h",
                        bus.wr_addr, bus.wr_data, e[36:32], e[31:0]);
            end
         end
      end
   end

   task automatic idle_inputs();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      bus.a_addr  = 5'd0;
      bus.b_addr  = 5'd0;
      bus.a_data  = 32'd0;
      bus.b_data  = 32'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.drop_cnt, bus.busy} !== 47'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%h drop=%0d busy=%b, expected all zero",
                  bus.wr_en, bus.wr_addr, bus.wr_data, bus.drop_cnt, bus.busy);
      end
      vectors++;
      if ({bus.a_ready, bus.b_ready} !== 2'b11) begin
         miscompares++;
         $display("FAIL reset_ready: got a=%b b=%b, expected 1 1", bus.a_ready, bus.b_ready);
      end
   endtask

   task automatic test_single();
      logic [2:0] seen;
      bus.a_valid = 1'b1;
      bus.a_addr  = 5'd5;
      bus.a_data  = 32'hDEADBEEF;
      exp_q.push_back({5'd5, 32'hDEADBEEF});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle_inputs();
         seen[i] = bus.wr_en;
      end
      vectors++;
      if (seen !== 3'b010) begin
         miscompares++;
         $display("FAIL single_latency: got wr_en over 3 cycles=%b, expected 010", seen);
      end
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_busy: got %b, expected 0", bus.busy);
      end
   endtask

   task automatic test_simultaneous();
      logic [4:0] first_addr;
      logic [4:0] second_addr;
`ifdef REGWR_RR_EN
      first_addr  = 5'd7;
      second_addr = 5'd3;
      exp_q.push_back({5'd7, 32'h22});
      exp_q.push_back({5'd3, 32'h11});
`else
      first_addr  = 5'd3;
      second_addr = 5'd7;
      exp_q.push_back({5'd3, 32'h11});
      exp_q.push_back({5'd7, 32'h22});
`endif
      bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h11;
      bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'h22;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      vectors++;
      if ({bus.wr_en, bus.wr_addr} !== {1'b1, first_addr}) begin
         miscompares++;
         $display("FAIL simul_first: got en=%b addr=%0d, expected en=1 addr=%0d", bus.wr_en, bus.wr_addr, first_addr);
      end
      @(negedge clk);
      vectors++;
      if ({bus.wr_en, bus.wr_addr} !== {1'b1, second_addr}) begin
         miscompares++;
         $display("FAIL simul_second: got en=%b addr=%0d, expected en=1 addr=%0d", bus.wr_en, bus.wr_addr, second_addr);
      end
      @(negedge clk);
   endtask

   task automatic test_starvation();
      int idx;
      int guard;
      int stalls;
      for (int k = 1; k <= 4; k++) exp_q.push_back({5'(k), 32'hA000_0000 + 32'(k)});
      exp_q.push_back({5'd9, 32'hB9});
      for (int k = 5; k <= 10; k++) exp_q.push_back({5'(k), 32'hA000_0000 + 32'(k)});
      idx = 1; guard = 0; stalls = 0;
      bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'hB9;
      while (idx <= 10 && guard < 60) begin
         bus.a_valid = 1'b1;
         bus.a_addr  = 5'(idx);
         bus.a_data  = 32'hA000_0000 + 32'(idx);
         if (bus.a_ready === 1'b1) idx++;
         else stalls++;
         guard++;
         @(negedge clk);
         bus.b_valid = 1'b0;
      end
      idle_inputs();
      vectors++;
      if (stalls != 1) begin
         miscompares++;
         $display("FAIL starve_a_stalls: got %0d stalled A cycles, expected 1", stalls);
      end
      guard = 0;
      while (exp_q.size() != 0 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL starve_drain: got %0d writes outstanding, expected 0", exp_q.size());
      end
      @(negedge clk);
   endtask

   task automatic test_drop();
      int exp_cnt;
      exp_cnt = 0;
      for (int i = 0; i < 150; i++) begin
         vectors++;
         if (bus.drop_cnt !== 8'(exp_cnt)) begin
            miscompares++;
            $display("FAIL drop_cnt_step%0d: got %0d, expected %0d", i, bus.drop_cnt, exp_cnt);
         end
         if (i == 0) begin
            vectors++;
            if ({bus.a_ready, bus.b_ready} !== 2'b11) begin
               miscompares++;
               $display("FAIL drop_ready: got a=%b b=%b, expected 1 1", bus.a_ready, bus.b_ready);
            end
         end
         bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'h5A5A5A5A;
         bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'hA5A5A5A5;
         exp_cnt = (exp_cnt + 2 > 255) ? 255 : exp_cnt + 2;
         @(negedge clk);
      end
      idle_inputs();
      vectors++;
      if (bus.drop_cnt !== 8'd255) begin
         miscompares++;
         $display("FAIL drop_saturate: got %0d, expected 255", bus.drop_cnt);
      end
      vectors++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b0, 5'd10, 32'hA000_000A}) begin
         miscompares++;
         $display("FAIL drop_idle_hold: got en=%b addr=%0d data=%h, expected en=0 addr=10 data=a000000a",
                  bus.wr_en, bus.wr_addr, bus.wr_data);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] en_seen;
      logic [3:0] rdy_seen;
      for (int i = 0; i < 8; i++) begin
         en_seen[i] = bus.wr_en;
         if (i < 4) begin
            bus.a_valid = 1'b1;
            bus.a_addr  = 5'(i + 1);
            bus.a_data  = 32'hC0DE_0000 + 32'(i);
            exp_q.push_back({5'(i + 1), 32'hC0DE_0000 + 32'(i)});
            rdy_seen[i] = bus.a_ready;
         end else begin
            idle_inputs();
         end
         @(negedge clk);
      end
      vectors++;
      if (rdy_seen !== 4'b1111) begin
         miscompares++;
         $display("FAIL b2b_ready: got %b, expected 1111", rdy_seen);
      end
      vectors++;
      if (en_seen !== 8'b0011_1100) begin
         miscompares++;
         $display("FAIL b2b_wr_en: got %b, expected 00111100", en_seen);
      end
   endtask

   task automatic test_reset_midop();
      bus.a_valid = 1'b1; bus.a_addr = 5'd12; bus.a_data = 32'h1212;
      bus.b_valid = 1'b1; bus.b_addr = 5'd13; bus.b_data = 32'h1313;
      @(negedge clk);
      idle_inputs();
      vectors++;
      if (bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midop_busy_before: got %b, expected 1", bus.busy);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if ({bus.wr_en, bus.busy, bus.drop_cnt, bus.a_ready, bus.b_ready, bus.wr_addr} !== {1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 5'd0}) begin
         miscompares++;
         $display("FAIL midop_after_reset: got en=%b busy=%b drop=%0d ar=%b br=%b addr=%0d, expected 0 0 0 1 1 0",
                  bus.wr_en, bus.busy, bus.drop_cnt, bus.a_ready, bus.b_ready, bus.wr_addr);
      end
      repeat (6) @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midop_busy_after: got %b, expected 0", bus.busy);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_single();
      test_simultaneous();
`ifndef REGWR_RR_EN
      test_starvation();
      test_drop();
`endif
      test_back_to_back();
      test_reset_midop();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL final_drain: got %0d writes never issued, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
